// File: rtl/util_pkg.sv
// Shared types and constants for the fetch front end.
package util_pkg;

    localparam int unsigned PC_BITS      = 32;
    localparam int unsigned INSTR_BITS   = 32;

    localparam int unsigned FQ_DEPTH     = 8;
    localparam int unsigned FQ_IN_LANES  = 2;
    localparam int unsigned FQ_OUT_LANES = 2;
    // Widest lane group the cut helper can scan.
    localparam int unsigned FQ_MAX_LANES = 32;

    typedef struct packed {
        logic [PC_BITS-1:0]    pc;
        logic [INSTR_BITS-1:0] data;
        logic                  taken_branch;
    } fetched_packet;

    typedef logic [$clog2(FQ_DEPTH)-1:0] fq_ptr_t;

    // Index of the first taken lane among the low 'lanes' bits; 'lanes' if none is taken.
    function automatic int unsigned fq_first_taken(input logic [FQ_MAX_LANES-1:0] taken,
                                                   input int unsigned lanes);
        int unsigned idx;
        logic        found;
        idx   = lanes;
        found = 1'b0;
        for (int unsigned i = 0; i < FQ_MAX_LANES; i++) begin
            if (!found && (i < lanes) && taken[i]) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fq_ring_ram.sv
// Flop-based ring storage: multi-lane write at base+k, multi-lane combinational read at base+k.
module fq_ring_ram
    import util_pkg::*;
#(
    parameter int unsigned DEPTH     = FQ_DEPTH,
    parameter int unsigned IN_LANES  = FQ_IN_LANES,
    parameter int unsigned OUT_LANES = FQ_OUT_LANES
) (
    input  logic                                clk,
    input  logic                                we,
    input  logic [$clog2(DEPTH)-1:0]            wr_base,
    input  logic [$clog2(IN_LANES+1)-1:0]       wr_count,
    input  fetched_packet [IN_LANES-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0]            rd_base,
    output fetched_packet [OUT_LANES-1:0]       rd_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned IN_W  = $clog2(IN_LANES + 1);

    fetched_packet mem [DEPTH];

    // Write lanes 0..wr_count-1 into consecutive slots, wrapping at DEPTH.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < int'(IN_LANES); k++) begin
                if (IN_W'(k) < wr_count) begin
                    mem[PTR_W'(wr_base + PTR_W'(k))] <= wr_data[k];
                end
            end
        end
    end

    // Lane k reads the slot k places after the read base.
    always_comb begin
        for (int k = 0; k < int'(OUT_LANES); k++) begin
            rd_data[k] = mem[PTR_W'(rd_base + PTR_W'(k))];
        end
    end

endmodule

// File: rtl/fetch_packet_queue.sv
// Multi-lane circular queue between fetch and decode with taken-branch group cut and flush.
module fetch_packet_queue
    import util_pkg::*;
#(
    parameter int unsigned IN_LANES     = FQ_IN_LANES,
    parameter int unsigned OUT_LANES    = FQ_OUT_LANES,
    parameter int unsigned DEPTH        = FQ_DEPTH,
    parameter bit          CUT_AT_TAKEN = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush_i,
    input  logic                              in_valid_i,
    input  logic [$clog2(IN_LANES+1)-1:0]     in_count_i,
    input  fetched_packet [IN_LANES-1:0]      in_packet_i,
    output logic                              in_ready_o,
    output logic [OUT_LANES-1:0]              out_valid_o,
    output fetched_packet [OUT_LANES-1:0]     out_packet_o,
    input  logic                              out_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]        count_o,
    output logic                              empty_o,
    output logic                              full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned IN_W  = $clog2(IN_LANES + 1);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]        head_q, tail_q;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        n_avail, n_out, n_in_eff, n_out_eff;
    logic [FQ_MAX_LANES-1:0] taken_vec;
    int unsigned             cut_len;
    logic                    enq_fire, deq_fire;

    fq_ring_ram #(
        .DEPTH     (DEPTH),
        .IN_LANES  (IN_LANES),
        .OUT_LANES (OUT_LANES)
    ) u_ram (
        .clk      (clk),
        .we       (enq_fire),
        .wr_base  (tail_q),
        .wr_count (in_count_i),
        .wr_data  (in_packet_i),
        .rd_base  (head_q),
        .rd_data  (out_packet_o)
    );

    // Status flags come from registered count only; same-cycle pops earn no credit.
    assign in_ready_o = (count_q <= CNT_W'(DEPTH - IN_LANES));
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_W'(DEPTH));

    assign enq_fire  = in_valid_i & in_ready_o & (in_count_i != '0) & ~flush_i;
    assign deq_fire  = out_ready_i & (n_out != '0) & ~flush_i;
    assign n_in_eff  = enq_fire ? CNT_W'(in_count_i) : '0;
    assign n_out_eff = deq_fire ? n_out : '0;

    // Output group size: available entries, optionally ending after the first taken branch.
    always_comb begin
        taken_vec = '0;
        for (int k = 0; k < int'(OUT_LANES); k++) begin
            taken_vec[k] = out_packet_o[k].taken_branch;
        end
        n_avail = (count_q < CNT_W'(OUT_LANES)) ? count_q : CNT_W'(OUT_LANES);
        cut_len = fq_first_taken(taken_vec, OUT_LANES) + 32'd1;
        n_out   = n_avail;
        if (CUT_AT_TAKEN && (cut_len < 32'(n_avail))) begin
            n_out = CNT_W'(cut_len);
        end
        out_valid_o = '0;
        for (int k = 0; k < int'(OUT_LANES); k++) begin
            out_valid_o[k] = (CNT_W'(k) < n_out);
        end
    end

    // Pointer and occupancy update; flush wins over any same-cycle traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            tail_q  <= tail_q + PTR_W'(n_in_eff);
            head_q  <= head_q + PTR_W'(n_out_eff);
            count_q <= count_q + n_in_eff - n_out_eff;
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CNT_W'(DEPTH));
    a_in_count_legal: assert property (@(posedge clk) disable iff (!rst_n)
        in_valid_i |-> (in_count_i <= IN_W'(IN_LANES)));
    a_no_enq_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        enq_fire |-> in_ready_o);
    a_valid_thermo: assert property (@(posedge clk) disable iff (!rst_n)
        ((out_valid_o + 1'b1) & out_valid_o) == '0);

endmodule

// File: tb/tb_fetch_packet_queue.sv
// Randomized and directed checking of fetch_packet_queue against a queue-based model.
module tb_fetch_packet_queue;
    import util_pkg::*;

    localparam int unsigned DEPTH = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                flush_i;
    logic                in_valid_i;
    logic [1:0]          in_count_i;
    fetched_packet [1:0] in_packet_i;
    logic                in_ready_o;
    logic [1:0]          out_valid_o;
    fetched_packet [1:0] out_packet_o;
    logic                out_ready_i;
    logic [3:0]          count_o;
    logic                empty_o;
    logic                full_o;

    int checks   = 0;
    int failures = 0;
    int unsigned pc_ctr = 32'h1000;

    fetched_packet mq[$];

    fetch_packet_queue dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .in_valid_i   (in_valid_i),
        .in_count_i   (in_count_i),
        .in_packet_i  (in_packet_i),
        .in_ready_o   (in_ready_o),
        .out_valid_o  (out_valid_o),
        .out_packet_o (out_packet_o),
        .out_ready_i  (out_ready_i),
        .count_o      (count_o),
        .empty_o      (empty_o),
        .full_o       (full_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Group size decode would receive: up to 2 oldest entries, ending after the first taken one.
    function automatic int model_nout();
        int avail;
        avail = (mq.size() < 2) ? mq.size() : 2;
        for (int i = 0; i < avail; i++) begin
            if (mq[i].taken_branch) return i + 1;
        end
        return avail;
    endfunction

    function automatic fetched_packet mk(input int unsigned pc, input logic taken);
        fetched_packet p;
        p.pc           = pc;
        p.data         = $urandom;
        p.taken_branch = taken;
        return p;
    endfunction

    task automatic check_model();
        int n;
        logic [1:0] expv;
        n    = model_nout();
        expv = 2'((1 << n) - 1);
        chk("count", 64'(count_o), 64'(mq.size()));
        chk("empty", 64'(empty_o), 64'(mq.size() == 0));
        chk("full", 64'(full_o), 64'(mq.size() == DEPTH));
        chk("in_ready", 64'(in_ready_o), 64'((DEPTH - mq.size()) >= 2));
        chk("out_valid", 64'(out_valid_o), 64'(expv));
        for (int k = 0; k < n; k++) begin
            chk("lane_pc", 64'(out_packet_o[k].pc), 64'(mq[k].pc));
            chk("lane_data", 64'(out_packet_o[k].data), 64'(mq[k].data));
            chk("lane_taken", 64'(out_packet_o[k].taken_branch), 64'(mq[k].taken_branch));
        end
    endtask

    // Drive one cycle of stimulus (called at negedge), advance the model, then check at next negedge.
    task automatic cycle(input logic f, input logic v, input logic [1:0] n,
                         input fetched_packet p0, input fetched_packet p1, input logic r);
        int  nout;
        logic rdy;
        nout = model_nout();
        rdy  = (DEPTH - mq.size()) >= 2;
        flush_i        = f;
        in_valid_i     = v;
        in_count_i     = n;
        in_packet_i[0] = p0;
        in_packet_i[1] = p1;
        out_ready_i    = r;
        if (f) begin
            mq.delete();
        end else begin
            if (r) begin
                for (int i = 0; i < nout; i++) void'(mq.pop_front());
            end
            if (v && rdy) begin
                if (n >= 2'd1) mq.push_back(p0);
                if (n >= 2'd2) mq.push_back(p1);
            end
        end
        @(posedge clk);
        @(negedge clk);
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        check_model();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 2'd0, mk(0, 1'b0), mk(0, 1'b0), 1'b0);
    endtask

    task automatic push(input int unsigned pc0, input logic t0, input int unsigned pc1,
                        input logic t1, input logic [1:0] n, input logic r);
        cycle(1'b0, 1'b1, n, mk(pc0, t0), mk(pc1, t1), r);
    endtask

    task automatic do_flush();
        cycle(1'b1, 1'b0, 2'd0, mk(0, 1'b0), mk(0, 1'b0), 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_count_i  = '0;
        in_packet_i = '0;
        out_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_empty", 64'(empty_o), 64'd1);
        chk("rst_full", 64'(full_o), 64'd0);
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_model();

        // Two-lane enqueue becomes visible the next cycle.
        push(32'h100, 1'b0, 32'h104, 1'b0, 2'd2, 1'b0);
        chk("t1_count", 64'(count_o), 64'd2);
        chk("t1_valid", 64'(out_valid_o), 64'h3);
        chk("t1_pc0", 64'(out_packet_o[0].pc), 64'h100);
        chk("t1_empty", 64'(empty_o), 64'd0);

        // Fill to DEPTH; a further push is refused.
        for (int i = 0; i < 3; i++) push(32'h108 + 8 * i, 1'b0, 32'h10c + 8 * i, 1'b0, 2'd2, 1'b0);
        chk("t2_full", 64'(full_o), 64'd1);
        chk("t2_in_ready", 64'(in_ready_o), 64'd0);
        chk("t2_count", 64'(count_o), 64'd8);
        push(32'h180, 1'b0, 32'h184, 1'b0, 2'd2, 1'b0);
        chk("t2_count_hold", 64'(count_o), 64'd8);

        // Count 7 also blocks a push.
        do_flush();
        for (int i = 0; i < 7; i++) push(32'h1a0 + 4 * i, 1'b0, 0, 1'b0, 2'd1, 1'b0);
        chk("t2_count7", 64'(count_o), 64'd7);
        chk("t2_ready7", 64'(in_ready_o), 64'd0);
        chk("t2_full7", 64'(full_o), 64'd0);

        // Walk head to slot 7, then push a group straddling the wrap.
        do_flush();
        push(32'h2f0, 1'b0, 0, 1'b0, 2'd1, 1'b0);
        for (int i = 0; i < 6; i++) push(32'h2f4 + 4 * i, 1'b0, 0, 1'b0, 2'd1, 1'b1);
        cycle(1'b0, 1'b0, 2'd0, mk(0, 1'b0), mk(0, 1'b0), 1'b1);
        chk("t3_count0", 64'(count_o), 64'd0);
        push(32'h300, 1'b0, 32'h304, 1'b0, 2'd2, 1'b0);
        chk("t3_valid", 64'(out_valid_o), 64'h3);
        chk("t3_pc0", 64'(out_packet_o[0].pc), 64'h300);
        chk("t3_pc1", 64'(out_packet_o[1].pc), 64'h304);
        chk("t3_slot7", 64'(dut.u_ram.mem[7].pc), 64'h300);
        chk("t3_slot0", 64'(dut.u_ram.mem[0].pc), 64'h304);

        // Taken branch in lane 0 cuts the group to one entry.
        do_flush();
        push(32'h200, 1'b1, 32'h204, 1'b0, 2'd2, 1'b0);
        chk("t4_valid", 64'(out_valid_o), 64'h1);
        cycle(1'b0, 1'b0, 2'd0, mk(0, 1'b0), mk(0, 1'b0), 1'b1);
        chk("t4_count", 64'(count_o), 64'd1);
        chk("t4_pc0", 64'(out_packet_o[0].pc), 64'h204);
        chk("t4_valid2", 64'(out_valid_o), 64'h1);

        // Flush beats simultaneous enqueue and dequeue.
        do_flush();
        push(32'h400, 1'b0, 32'h404, 1'b0, 2'd2, 1'b0);
        push(32'h408, 1'b0, 32'h40c, 1'b0, 2'd2, 1'b0);
        push(32'h410, 1'b0, 0, 1'b0, 2'd1, 1'b0);
        chk("t5_count5", 64'(count_o), 64'd5);
        cycle(1'b1, 1'b1, 2'd2, mk(32'h500, 1'b0), mk(32'h504, 1'b0), 1'b1);
        chk("t5_count", 64'(count_o), 64'd0);
        chk("t5_empty", 64'(empty_o), 64'd1);
        chk("t5_valid", 64'(out_valid_o), 64'd0);
        idle();
        chk("t5_still_empty", 64'(count_o), 64'd0);

        // Random traffic with 30% decode back-pressure and rare flushes.
        for (int c = 0; c < 10000; c++) begin
            logic       f, v, r;
            logic [1:0] n;
            f  = ($urandom_range(0, 199) == 0);
            v  = ($urandom_range(0, 9) < 8);
            n  = 2'($urandom_range(0, 2));
            r  = ($urandom_range(0, 9) >= 3);
            cycle(f, v, n, mk(pc_ctr, $urandom_range(0, 3) == 0),
                  mk(pc_ctr + 4, $urandom_range(0, 3) == 0), r);
            pc_ctr += 8;
        end

        // Mid-operation reset clears immediately; enqueue allowed right after release.
        push(32'h600, 1'b0, 32'h604, 1'b0, 2'd2, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_count", 64'(count_o), 64'd0);
        chk("rst_mid_empty", 64'(empty_o), 64'd1);
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        check_model();
        push(32'h700, 1'b0, 32'h704, 1'b0, 2'd2, 1'b0);
        chk("rst_after_count", 64'(count_o), 64'd2);
        chk("rst_after_pc0", 64'(out_packet_o[0].pc), 64'h700);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
